// File: rtl/state_seq_gen.sv
// 4-bit protocol state sequencer: walks the legal transition graph, counts loops back to 0
// and flags recovery from undefined encodings. Define STATE_SEQ_GEN_FORCE_EN for state injection.
module state_seq_gen #(
  parameter int         LOOP_W    = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto,
  input  logic [1:0]        sel,
  input  logic              force_vld,
  input  logic [3:0]        force_state,
  output logic [3:0]        state,
  output logic [LOOP_W-1:0] loop_cnt,
  output logic              dflt_hit
);

  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [3:0] {
    S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
    S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
    S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11,
    S12 = 4'd12, S13 = 4'd13, S14 = 4'd14, S15 = 4'd15
  } state_t;

  state_t     cur, nxt, state_d;
  logic [7:0] lfsr;
  logic [1:0] s;
  logic       forced, loop_close, recover;

`ifdef STATE_SEQ_GEN_FORCE_EN
  assign forced = force_vld;
`else
  assign forced = 1'b0;
  wire unused_force = ^{force_vld, force_state};
`endif

  assign s = auto ? lfsr[1:0] : sel;

  always_comb begin
    nxt     = S4;
    recover = 1'b0;
    case (cur)
      S0:  nxt = S1;
      S1:  nxt = s[0] ? S4 : S2;
      S2:  nxt = S3;
      S3:  nxt = s[0] ? S1 : S5;
      S4:  nxt = S5;
      S5:  nxt = s[0] ? S1 : S6;
      S6:  nxt = S7;
      S7:  nxt = s[0] ? S0 : S8;
      S8:  case (s)
             2'b00:   nxt = S2;
             2'b01:   nxt = S4;
             2'b10:   nxt = S9;
             default: nxt = S14;
           endcase
      S9:  nxt = S0;
      S14: nxt = S0;
      default: begin
        nxt     = S4;
        recover = 1'b1;
      end
    endcase
  end

  // Only 7, 9 and 14 lead to 0 in the graph, so a graph step into 0 is a completed loop.
  always_comb begin
    state_d    = forced ? state_t'(force_state) : nxt;
    loop_close = !forced && (nxt == S0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S0;
      lfsr     <= SEED;
      loop_cnt <= '0;
      dflt_hit <= 1'b0;
    end else begin
      cur      <= state_d;
      dflt_hit <= recover && !forced;
      // Galois shift; a nonzero seed never decays to zero.
      if (auto)
        lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      if (loop_close && !(&loop_cnt))
        loop_cnt <= loop_cnt + LOOP_W'(1);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_state_seq_gen.sv
// Bench for state_seq_gen: table-driven reference model compared every cycle, plus literal sequences.
module tb_state_seq_gen;

`ifdef STATE_SEQ_GEN_FORCE_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auto = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       force_vld = 1'b0;
  logic [3:0] force_state = 4'd0;

  logic [3:0] st1, st2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic       dh1, dh2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  state_seq_gen #(.LOOP_W(8), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .auto(auto), .sel(sel), .force_vld(force_vld),
    .force_state(force_state), .state(st1), .loop_cnt(cnt1), .dflt_hit(dh1));

  state_seq_gen #(.LOOP_W(2), .LFSR_SEED(8'h00)) dut2 (
    .clk(clk), .rst(rst), .auto(auto), .sel(sel), .force_vld(force_vld),
    .force_state(force_state), .state(st2), .loop_cnt(cnt2), .dflt_hit(dh2));

  // Transition table: next state for s[0]=0 / s[0]=1; state 8 picks by full s.
  int nx0[16] = '{1, 2, 3, 5, 5, 6, 7, 8, 2, 0, 4, 4, 4, 4, 0, 4};
  int nx1[16] = '{1, 4, 3, 1, 5, 1, 7, 0, 4, 0, 4, 4, 4, 4, 0, 4};
  int nx8[4]  = '{2, 4, 9, 14};

  int         m_st[2];
  logic [7:0] m_lfsr[2];
  int         m_cnt[2];
  int         m_dh[2];
  int         m_max[2]  = '{255, 3};
  logic [7:0] m_seed[2] = '{8'hA5, 8'h01};

  function automatic bit undef_enc(input int v);
    return (v >= 10 && v <= 13) || v == 15;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] ms;
    int         n;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = 0; m_lfsr[i] = m_seed[i]; m_cnt[i] = 0; m_dh[i] = 0;
      end else begin
        ms = auto ? m_lfsr[i][1:0] : sel;
        n  = (m_st[i] == 8) ? nx8[ms] : (ms[0] ? nx1[m_st[i]] : nx0[m_st[i]]);
        if (FEN && force_vld) begin
          m_dh[i] = 0;
          m_st[i] = int'(force_state);
        end else begin
          m_dh[i] = undef_enc(m_st[i]) ? 1 : 0;
          if (n == 0 && m_cnt[i] < m_max[i]) m_cnt[i]++;
          m_st[i] = n;
        end
        if (auto) m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 8'hB8 : 8'h00);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    #1;
    chk("state", {28'd0, st1}, m_st[0]);
    chk("loop_cnt", {24'd0, cnt1}, m_cnt[0]);
    chk("dflt_hit", {31'd0, dh1}, m_dh[0]);
    chk("state_w2", {28'd0, st2}, m_st[1]);
    chk("loop_cnt_w2", {30'd0, cnt2}, m_cnt[1]);
    chk("dflt_hit_w2", {31'd0, dh2}, m_dh[1]);
    chk("lfsr_nonzero", {31'd0, (m_lfsr[0] != 0 && m_lfsr[1] != 0)}, 1);
    if (!FEN) chk("no_undef_state", {31'd0, undef_enc(int'(st1))}, 0);
  end

  task automatic step(input int exp_st, input string nm);
    @(posedge clk); #1;
    chk(nm, {28'd0, st1}, exp_st);
  endtask

  task automatic async_reset();
    rst = 1'b1; #1;
    chk("rst_state", {28'd0, st1}, 0);
    chk("rst_loop_cnt", {24'd0, cnt1}, 0);
    chk("rst_dflt", {31'd0, dh1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int seq_a[9] = '{1, 2, 3, 5, 6, 7, 8, 2, 3};
  int seq_b[7] = '{1, 4, 5, 1, 4, 5, 1};
  int to8[7]   = '{1, 2, 3, 5, 6, 7, 8};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_state", {28'd0, st1}, 0);
    chk("init_loop_cnt", {24'd0, cnt1}, 0);
    chk("init_dflt", {31'd0, dh1}, 0);
    rst = 1'b0;

    // Basic path with sel=00
    foreach (seq_a[k]) step(seq_a[k], "basic_path");
    chk("basic_loop_cnt", {24'd0, cnt1}, 0);

    // Alternate branches with sel=01
    async_reset();
    sel = 2'b01;
    foreach (seq_b[k]) step(seq_b[k], "alt_path");

    // Returns to 0 via 9 and via 14
    async_reset();
    sel = 2'b00;
    foreach (to8[k]) step(to8[k], "steer_8a");
    sel = 2'b10; step(9, "via_9"); step(0, "via_9_zero");
    chk("loop_cnt_1", {24'd0, cnt1}, 1);
    sel = 2'b00;
    foreach (to8[k]) step(to8[k], "steer_8b");
    sel = 2'b11; step(14, "via_14"); step(0, "via_14_zero");
    chk("loop_cnt_2", {24'd0, cnt1}, 2);

    // Reset mid-run at state 6, then saturation on the narrow counter
    sel = 2'b00;
    for (int k = 0; k < 5; k++) step(to8[k], "steer_6");
    async_reset();
    for (int l = 0; l < 5; l++) begin
      sel = 2'b00;
      foreach (to8[k]) step(to8[k], "sat_steer");
      sel = 2'b10; step(9, "sat_9"); step(0, "sat_zero");
    end
    chk("sat_w2", {30'd0, cnt2}, 3);
    chk("sat_w8", {24'd0, cnt1}, 5);

    // Force injection and default recovery
    sel = 2'b00;
    force_vld = 1'b1; force_state = 4'd12;
`ifdef STATE_SEQ_GEN_FORCE_EN
    step(12, "force_12");
    force_vld = 1'b0;
    step(4, "recover_4");
    chk("dflt_pulse", {31'd0, dh1}, 1);
    step(5, "after_recover");
    chk("dflt_clear", {31'd0, dh1}, 0);
    step(6, "to_6"); step(7, "to_7");
    sel = 2'b01; force_vld = 1'b1; force_state = 4'd0;
    step(0, "force_0_over_loop");
    chk("force_no_count", {24'd0, cnt1}, 5);
    force_vld = 1'b0;
`else
    step(1, "force_ignored");
    chk("force_ignored_dflt", {31'd0, dh1}, 0);
    force_vld = 1'b0;
`endif

    // Free run on the LFSR
    auto = 1'b1;
    repeat (1000) @(posedge clk);
    #1;

    // Mixed random: auto toggling, random sel, occasional force
    for (int k = 0; k < 500; k++) begin
      auto        = ($urandom_range(0, 3) != 0);
      sel         = 2'($urandom_range(0, 3));
      force_vld   = ($urandom_range(0, 19) == 0);
      force_state = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    force_vld = 1'b0;
    @(posedge clk); #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_seq_gen.md
# state_seq_gen

Drives the 4-bit protocol state sequence that the state-transition checker monitors. Every clock it advances along the legal transition graph, choosing among branches from an external select or an internal LFSR. It reports completed loops and recoveries from undefined encodings. It sits on the interface alongside the checker and is the source of the `state` signal that the checker samples.

## Interface
- `LOOP_W`, default 8: width of the loop counter.
- `LFSR_SEED`, default 8'hA5: LFSR reset value. A value of 0 is replaced by 8'h01.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `auto`  in  1  1 = branch select comes from the LFSR; 0 = branch select comes from `sel`.
- `sel`  in  2  external branch select, sampled at each edge.
- `force_vld`  in  1  state-injection strobe; active only when the force feature is compiled in.
- `force_state`  in  4  state value to inject.
- `state`  out  4  current state, registered.
- `loop_cnt`  out  LOOP_W  saturating count of returns to state 0.
- `dflt_hit`  out  1  1-cycle flag: `state` has just recovered from an undefined encoding.

## Operation
- Effective select `s`:
  - `s = lfsr[1:0]` when `auto` = 1.
  - `s = sel` when `auto` = 0.
- Next-state function. `state` advances on every edge; there is no hold.
  - 0 → 1
  - 1 → 2 if s[0]=0, else 4
  - 2 → 3
  - 3 → 5 if s[0]=0, else 1
  - 4 → 5
  - 5 → 6 if s[0]=0, else 1
  - 6 → 7
  - 7 → 8 if s[0]=0, else 0
  - 8 → 2 if s=00; 4 if s=01; 9 if s=10; 14 if s=11
  - 9 → 0
  - 14 → 0
  - 10, 11, 12, 13, 15 → 4
- States 10–13 and 15 are never produced by the transition graph. They can only be reached through force injection.
- LFSR:
  - 8-bit Galois, taps 8'hB8 (x^8+x^6+x^5+x^4+1).
  - Shifts every edge while `auto` = 1; holds while `auto` = 0.
  - Never reaches zero.
- `loop_cnt`:
  - Increments by 1 on each 7→0, 9→0 or 14→0 transition.
  - Saturates at all-ones; no wrap.
  - Reset does not count as a loop.
- `dflt_hit`:
  - Registered to 1 on the edge that takes `state` from {10–13, 15} to 4.
  - 0 on every other edge.
- Force:
  - When compiled in and `force_vld` = 1 at an edge, `state` loads `force_state` and overrides the graph.
  - `loop_cnt` does not increment on a forced edge, even if `force_state` = 0.
  - `dflt_hit` = 0 on a forced edge.

## Timing
- All outputs are registered. The next state is a function of the current `state` and `s` at the same edge, so latency is one cycle.
- Reset values: `state` = 0, `loop_cnt` = 0, `dflt_hit` = 0, lfsr = `LFSR_SEED` (or 8'h01 when the seed is 0).
- Asserting `rst` mid-operation clears all outputs immediately, without waiting for a clock edge.
- First transition after reset: the first rising edge with `rst` low moves `state` from 0 to 1.
- `auto` toggling takes effect at the same edge. The LFSR value used at that edge is its current, pre-shift value.
- Simultaneous force and a loop-closing graph transition: force wins and the counter does not change.

## Configuration
- Macro: `STATE_SEQ_GEN_FORCE_EN`.
- Defined: `force_vld` / `force_state` inject states as described in Operation. Used to exercise the checker's illegal-transition and default-recovery paths.
- Undefined: both force inputs are ignored. The block emits only legal transitions, so `dflt_hit` stays 0.

## Test plan
- Basic path: release `rst`, hold `auto` = 0 and `sel` = 00 → `state` sequence 0,1,2,3,5,6,7,8,2,3; `loop_cnt` stays 0.
- Alternate branches: `auto` = 0, `sel` = 01 → sequence 0,1,4,5,1,4,5,1; `dflt_hit` never asserts.
- Returns to 0: steer to 8 with `sel` = 00 (0,1,2,3,5,6,7,8), then `sel` = 10 → 9, 0 and `loop_cnt` = 1. Steer to 8 again, then `sel` = 11 → 14, 0 and `loop_cnt` = 2.
- Force and recovery (with `STATE_SEQ_GEN_FORCE_EN`): `force_vld` = 1, `force_state` = 12 for one edge → `state` = 12, then 4 with `dflt_hit` = 1 for one cycle, then 5.
- Free run: `auto` = 1, seed 8'hA5, 1000 cycles → `state` matches a reference model cycle for cycle, never enters {10–13, 15}, and the LFSR never reaches 0.
- Reset and saturation: assert `rst` while `state` = 6 → `state` = 0 and `loop_cnt` = 0 immediately. Then with `LOOP_W` = 2, complete 5 loops → `loop_cnt` holds at 3.
